// File: rtl/myniosiicpu_cpu_jtag_cmd_sync_if.sv
// Command bus between the JTAG sysclk command synchroniser (master) and the
// OCI break / ocimem / trace / tracemem consumers (slave).
interface myniosiicpu_cpu_jtag_cmd_sync_if #(
  parameter int SR_W = 38,
  parameter int IR_W = 2
);
  localparam int NUM_CH = 2 ** IR_W;

  logic              cmd_valid;
  logic              cmd_ready;
  logic [IR_W-1:0]   cmd_ch;
  logic [SR_W-1:0]   cmd_jdo;
  logic [NUM_CH-1:0] take_action;
  logic [NUM_CH-1:0] take_no_action;

  modport master (
    output cmd_valid,
    output cmd_ch,
    output cmd_jdo,
    output take_action,
    output take_no_action,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_ch,
    input  cmd_jdo,
    input  take_action,
    input  take_no_action,
    output cmd_ready
  );
endinterface

// File: rtl/myniosiicpu_cpu_jtag_cmd_sync.sv
// System-clock side of the Nios II JTAG debug link: synchronises the TCK update
// strobes and queues decoded commands. MYNIOSIICPU_JTAG_CMD_FIFO_EN selects a
// FIFO_DEPTH-entry queue; otherwise a single holding register is used.
module myniosiicpu_cpu_jtag_cmd_sync #(
  parameter int SR_W       = 38,
  parameter int IR_W       = 2,
  parameter int ACT_BIT    = 34,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         vs_udr,
  input  logic                         vs_uir,
  input  logic [IR_W-1:0]              ir_in,
  input  logic [SR_W-1:0]              sr,
  myniosiicpu_cpu_jtag_cmd_sync_if.master cmd_if,
  output logic                         ir_update,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_level,
  output logic                         overflow,
  input  logic                         overflow_clr
);

  localparam int NUM_CH = 2 ** IR_W;
  localparam int LVL_W  = $clog2(FIFO_DEPTH) + 1;

  // Stage p0..p2: three-flop synchronisers for the asynchronous update strobes
  logic udr_p0, udr_p1, udr_p2;
  logic uir_p0, uir_p1, uir_p2;

  always_ff @(posedge clk) begin
    if (reset) begin
      udr_p0 <= 1'b0;
      udr_p1 <= 1'b0;
      udr_p2 <= 1'b0;
      uir_p0 <= 1'b0;
      uir_p1 <= 1'b0;
      uir_p2 <= 1'b0;
    end else begin
      udr_p0 <= vs_udr;
      udr_p1 <= udr_p0;
      udr_p2 <= udr_p1;
      uir_p0 <= vs_uir;
      uir_p1 <= uir_p0;
      uir_p2 <= uir_p1;
    end
  end

  // Edges are ignored until the chains have refilled after reset, so a strobe
  // held high through reset is not mistaken for a fresh update.
  typedef enum logic [1:0] {
    ARM_W0,
    ARM_W1,
    ARM_W2,
    ARM_LIVE
  } arm_state_t;

  arm_state_t arm_state, arm_next;
  logic       armed;

  always_ff @(posedge clk) begin
    if (reset) arm_state <= ARM_W0;
    else       arm_state <= arm_next;
  end

  always_comb begin
    arm_next = arm_state;
    armed    = 1'b0;
    case (arm_state)
      ARM_W0:   arm_next = ARM_W1;
      ARM_W1:   arm_next = ARM_W2;
      ARM_W2:   arm_next = ARM_LIVE;
      ARM_LIVE: armed    = 1'b1;
      default:  arm_next = ARM_W0;
    endcase
  end

  logic udr_rise, uir_rise;

  assign udr_rise = armed & udr_p1 & ~udr_p2;
  assign uir_rise = armed & uir_p1 & ~uir_p2;

  always_ff @(posedge clk) begin
    if (reset) ir_update <= 1'b0;
    else       ir_update <= uir_rise;
  end

  // Queue control shared by both storage variants
  logic              head_vld;
  logic [IR_W-1:0]   head_ch;
  logic [SR_W-1:0]   head_jdo;
  logic              q_full;
  logic              pop, push_ok, drop;

  assign pop     = head_vld & cmd_if.cmd_ready;
  assign push_ok = udr_rise & (~q_full | pop);
  assign drop    = udr_rise & q_full & ~pop;

`ifdef MYNIOSIICPU_JTAG_CMD_FIFO_EN
  localparam int AW = $clog2(FIFO_DEPTH);

  // Extra MSB on each pointer separates full from empty when the indices match
  logic [AW:0]     wr_ptr, rd_ptr;
  logic [IR_W-1:0] ch_mem  [FIFO_DEPTH];
  logic [SR_W-1:0] jdo_mem [FIFO_DEPTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      ch_mem[wr_ptr[AW-1:0]]  <= ir_in;
      jdo_mem[wr_ptr[AW-1:0]] <= sr;
    end
  end

  assign head_vld   = (wr_ptr != rd_ptr);
  assign q_full     = ((wr_ptr ^ rd_ptr) == {1'b1, {AW{1'b0}}});
  assign head_ch    = ch_mem[rd_ptr[AW-1:0]];
  assign head_jdo   = jdo_mem[rd_ptr[AW-1:0]];
  assign fifo_level = wr_ptr - rd_ptr;
`else
  logic            hold_vld;
  logic [IR_W-1:0] hold_ch;
  logic [SR_W-1:0] hold_jdo;

  always_ff @(posedge clk) begin
    if (reset)        hold_vld <= 1'b0;
    else if (push_ok) hold_vld <= 1'b1;
    else if (pop)     hold_vld <= 1'b0;
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      hold_ch  <= ir_in;
      hold_jdo <= sr;
    end
  end

  assign head_vld   = hold_vld;
  assign q_full     = hold_vld;
  assign head_ch    = hold_ch;
  assign head_jdo   = hold_jdo;
  assign fifo_level = LVL_W'(hold_vld);
`endif

  always_ff @(posedge clk) begin
    if (reset)             overflow <= 1'b0;
    else if (overflow_clr) overflow <= 1'b0;
    else if (drop)         overflow <= 1'b1;
  end

  // Head is zeroed while empty so the unreset storage never leaks out
  assign cmd_if.cmd_valid = head_vld;
  assign cmd_if.cmd_ch    = head_vld ? head_ch  : '0;
  assign cmd_if.cmd_jdo   = head_vld ? head_jdo : '0;

  logic [NUM_CH-1:0] act_vec, noact_vec;

  always_comb begin
    act_vec   = '0;
    noact_vec = '0;
    if (pop) begin
      if (head_jdo[ACT_BIT]) act_vec[head_ch]   = 1'b1;
      else                   noact_vec[head_ch] = 1'b1;
    end
  end

  assign cmd_if.take_action    = act_vec;
  assign cmd_if.take_no_action = noact_vec;

endmodule

// File: tb/tb_myniosiicpu_cpu_jtag_cmd_sync.sv
// Self-checking bench for the JTAG sysclk command synchroniser/queue; the
// expected queue contents come from a plain SV queue model of the command rules.
module tb_myniosiicpu_cpu_jtag_cmd_sync;
  localparam int SR_W       = 38;
  localparam int IR_W       = 2;
  localparam int NUM_CH     = 4;
  localparam int ACT_BIT    = 34;
  localparam int FIFO_DEPTH = 4;
  localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1;
`ifdef MYNIOSIICPU_JTAG_CMD_FIFO_EN
  localparam int EFF_DEPTH = FIFO_DEPTH;
`else
  localparam int EFF_DEPTH = 1;
`endif

  typedef struct packed {
    logic [IR_W-1:0] ch;
    logic [SR_W-1:0] jdo;
  } cmd_t;

  logic             clk = 1'b0;
  logic             reset, vs_udr, vs_uir, overflow_clr, ir_update, overflow;
  logic [IR_W-1:0]  ir_in;
  logic [SR_W-1:0]  sr;
  logic [LVL_W-1:0] fifo_level;

  myniosiicpu_cpu_jtag_cmd_sync_if #(.SR_W(SR_W), .IR_W(IR_W)) cmd_if ();

  myniosiicpu_cpu_jtag_cmd_sync #(
    .SR_W(SR_W), .IR_W(IR_W), .ACT_BIT(ACT_BIT), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .reset(reset), .vs_udr(vs_udr), .vs_uir(vs_uir),
    .ir_in(ir_in), .sr(sr), .cmd_if(cmd_if), .ir_update(ir_update),
    .fifo_level(fifo_level), .overflow(overflow), .overflow_clr(overflow_clr)
  );

  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_pass   = 0;
  cmd_t q[$];
  bit   m_ovf;

  function automatic cmd_t rand_cmd(input int act);
    cmd_t c;
    c.ch  = IR_W'($urandom_range(NUM_CH - 1));
    c.jdo = SR_W'({$urandom(), $urandom()});
    if (act >= 0) c.jdo[ACT_BIT] = act[0];
    return c;
  endfunction

  function automatic logic [NUM_CH-1:0] onehot(input logic [IR_W-1:0] ch);
    logic [NUM_CH-1:0] v;
    v     = '0;
    v[ch] = 1'b1;
    return v;
  endfunction

  // Queue model for one clock edge: pop first, then push if room, clear wins.
  function automatic void model_apply(input bit pop, input bit push, input cmd_t c, input bit clr);
    if (pop && q.size() != 0) void'(q.pop_front());
    if (push) begin
      if (q.size() < EFF_DEPTH) q.push_back(c);
      else m_ovf = 1'b1;
    end
    if (clr) m_ovf = 1'b0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; vs_udr = 1'b0; vs_uir = 1'b0;
    cmd_if.cmd_ready = 1'b0; overflow_clr = 1'b0;
    tick(); tick();
    reset = 1'b0;
    q.delete(); m_ovf = 1'b0;
    repeat (4) tick();
  endtask

  // One update-DR strobe: 4 clk high then 3 clk low; caller holds cmd_ready low.
  task automatic send(input cmd_t c);
    ir_in = c.ch; sr = c.jdo; vs_udr = 1'b1;
    repeat (4) tick();
    vs_udr = 1'b0;
    repeat (3) tick();
    model_apply(1'b0, 1'b1, c, 1'b0);
  endtask

  task automatic test_reset();
    reset = 1'b1; vs_udr = 1'b0; vs_uir = 1'b0; overflow_clr = 1'b0;
    cmd_if.cmd_ready = 1'b1; ir_in = '1; sr = '1;
    repeat (3) tick();
    n_checks++; if (cmd_if.cmd_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", cmd_if.cmd_valid); else n_pass++;
    n_checks++; if (cmd_if.take_action !== '0) $display("FAIL reset_take_action: got %b want 0", cmd_if.take_action); else n_pass++;
    n_checks++; if (cmd_if.take_no_action !== '0) $display("FAIL reset_take_no_action: got %b want 0", cmd_if.take_no_action); else n_pass++;
    n_checks++; if (ir_update !== 1'b0) $display("FAIL reset_ir_update: got %b want 0", ir_update); else n_pass++;
    n_checks++; if (fifo_level !== '0) $display("FAIL reset_level: got %0d want 0", fifo_level); else n_pass++;
    n_checks++; if (overflow !== 1'b0) $display("FAIL reset_overflow: got %b want 0", overflow); else n_pass++;
    n_checks++; if (cmd_if.cmd_ch !== '0) $display("FAIL reset_cmd_ch: got %0d want 0", cmd_if.cmd_ch); else n_pass++;
    n_checks++; if (cmd_if.cmd_jdo !== '0) $display("FAIL reset_cmd_jdo: got %h want 0", cmd_if.cmd_jdo); else n_pass++;
    reset = 1'b0; cmd_if.cmd_ready = 1'b0;
    q.delete(); m_ovf = 1'b0;
    repeat (4) tick();
    n_checks++; if (cmd_if.cmd_valid !== 1'b0 || fifo_level !== '0) $display("FAIL reset_release: valid %b level %0d want 0/0", cmd_if.cmd_valid, fifo_level); else n_pass++;
  endtask

  task automatic test_single();
    cmd_t c;
    c.ch  = 2'd2;
    c.jdo = 38'h6_0000_00AB;
    cmd_if.cmd_ready = 1'b0; ir_in = c.ch; sr = c.jdo; vs_udr = 1'b1;
    for (int e = 1; e <= 3; e++) begin
      tick();
      n_checks++;
      if (cmd_if.cmd_valid !== (e == 3)) $display("FAIL single_latency edge %0d: valid %b want %b", e, cmd_if.cmd_valid, (e == 3));
      else n_pass++;
    end
    n_checks++; if (cmd_if.cmd_jdo !== c.jdo) $display("FAIL single_jdo: got %h want %h", cmd_if.cmd_jdo, c.jdo); else n_pass++;
    n_checks++; if (cmd_if.cmd_ch !== c.ch) $display("FAIL single_ch: got %0d want %0d", cmd_if.cmd_ch, c.ch); else n_pass++;
    n_checks++; if (fifo_level !== LVL_W'(1)) $display("FAIL single_level: got %0d want 1", fifo_level); else n_pass++;
    cmd_if.cmd_ready = 1'b1;
    #1;
    n_checks++; if (cmd_if.take_action !== 4'b0100) $display("FAIL single_take_action: got %b want 0100", cmd_if.take_action); else n_pass++;
    n_checks++; if (cmd_if.take_no_action !== 4'b0000) $display("FAIL single_take_no_action: got %b want 0000", cmd_if.take_no_action); else n_pass++;
    tick();
    n_checks++; if (cmd_if.cmd_valid !== 1'b0 || cmd_if.take_action !== '0) $display("FAIL single_after_pop: valid %b take %b want 0/0000", cmd_if.cmd_valid, cmd_if.take_action); else n_pass++;
    vs_udr = 1'b0; cmd_if.cmd_ready = 1'b0;
    repeat (3) tick();
  endtask

  task automatic test_no_action();
    cmd_t c;
    c    = rand_cmd(0);
    c.ch = 2'd0;
    send(c);
    n_checks++; if (cmd_if.cmd_valid !== 1'b1 || {cmd_if.cmd_ch, cmd_if.cmd_jdo} !== q[0]) $display("FAIL noact_head: valid %b ch %0d jdo %h want 1/%0d/%h", cmd_if.cmd_valid, cmd_if.cmd_ch, cmd_if.cmd_jdo, q[0].ch, q[0].jdo); else n_pass++;
    cmd_if.cmd_ready = 1'b1;
    #1;
    n_checks++; if (cmd_if.take_no_action !== 4'b0001) $display("FAIL noact_take_no_action: got %b want 0001", cmd_if.take_no_action); else n_pass++;
    n_checks++; if (cmd_if.take_action !== 4'b0000) $display("FAIL noact_take_action: got %b want 0000", cmd_if.take_action); else n_pass++;
    tick();
    cmd_if.cmd_ready = 1'b0;
    void'(q.pop_front());
    n_checks++; if (cmd_if.cmd_valid !== 1'b0) $display("FAIL noact_empty: valid %b want 0", cmd_if.cmd_valid); else n_pass++;
  endtask

  task automatic test_overflow();
    cmd_t sent[5];
    logic [NUM_CH-1:0] ea, en;
    do_reset();
    for (int k = 0; k < 5; k++) begin
      sent[k] = rand_cmd(-1);
      send(sent[k]);
    end
    n_checks++; if (fifo_level !== LVL_W'(EFF_DEPTH)) $display("FAIL ovf_level: got %0d want %0d", fifo_level, EFF_DEPTH); else n_pass++;
    n_checks++; if (overflow !== 1'b1) $display("FAIL ovf_flag: got %b want 1", overflow); else n_pass++;
    cmd_if.cmd_ready = 1'b1;
    for (int k = 0; k < EFF_DEPTH; k++) begin
      #1;
      ea = sent[k].jdo[ACT_BIT] ? onehot(sent[k].ch) : '0;
      en = sent[k].jdo[ACT_BIT] ? '0 : onehot(sent[k].ch);
      n_checks++; if ({cmd_if.cmd_ch, cmd_if.cmd_jdo} !== sent[k]) $display("FAIL ovf_order %0d: ch %0d jdo %h want %0d/%h", k, cmd_if.cmd_ch, cmd_if.cmd_jdo, sent[k].ch, sent[k].jdo); else n_pass++;
      n_checks++; if (cmd_if.take_action !== ea || cmd_if.take_no_action !== en) $display("FAIL ovf_pulse %0d: act %b noact %b want %b/%b", k, cmd_if.take_action, cmd_if.take_no_action, ea, en); else n_pass++;
      tick();
    end
    cmd_if.cmd_ready = 1'b0;
    q.delete();
    n_checks++; if (cmd_if.cmd_valid !== 1'b0 || overflow !== 1'b1) $display("FAIL ovf_drained: valid %b ovf %b want 0/1", cmd_if.cmd_valid, overflow); else n_pass++;
    overflow_clr = 1'b1;
    tick();
    overflow_clr = 1'b0; m_ovf = 1'b0;
    n_checks++; if (overflow !== 1'b0) $display("FAIL ovf_clear: got %b want 0", overflow); else n_pass++;
  endtask

  task automatic test_full_pop();
    cmd_t nc, h;
    logic [NUM_CH-1:0] ea, en;
    do_reset();
    for (int k = 0; k < EFF_DEPTH; k++) send(rand_cmd(-1));
    nc = rand_cmd(-1);
    ir_in = nc.ch; sr = nc.jdo; vs_udr = 1'b1;
    tick(); tick();
    cmd_if.cmd_ready = 1'b1;
    #1;
    h  = q[0];
    ea = h.jdo[ACT_BIT] ? onehot(h.ch) : '0;
    en = h.jdo[ACT_BIT] ? '0 : onehot(h.ch);
    n_checks++; if (cmd_if.take_action !== ea || cmd_if.take_no_action !== en) $display("FAIL fullpop_pulse: act %b noact %b want %b/%b", cmd_if.take_action, cmd_if.take_no_action, ea, en); else n_pass++;
    tick();
    cmd_if.cmd_ready = 1'b0;
    model_apply(1'b1, 1'b1, nc, 1'b0);
    n_checks++; if (fifo_level !== LVL_W'(EFF_DEPTH)) $display("FAIL fullpop_level: got %0d want %0d", fifo_level, EFF_DEPTH); else n_pass++;
    n_checks++; if (overflow !== 1'b0) $display("FAIL fullpop_overflow: got %b want 0", overflow); else n_pass++;
    tick();
    vs_udr = 1'b0;
    repeat (3) tick();
    cmd_if.cmd_ready = 1'b1;
    while (q.size() != 0) begin
      #1;
      n_checks++; if ({cmd_if.cmd_ch, cmd_if.cmd_jdo} !== q[0]) $display("FAIL fullpop_order: ch %0d jdo %h want %0d/%h", cmd_if.cmd_ch, cmd_if.cmd_jdo, q[0].ch, q[0].jdo); else n_pass++;
      void'(q.pop_front());
      tick();
    end
    cmd_if.cmd_ready = 1'b0;
    n_checks++; if (cmd_if.cmd_valid !== 1'b0) $display("FAIL fullpop_empty: valid %b want 0", cmd_if.cmd_valid); else n_pass++;
  endtask

  task automatic test_reset_mid();
    cmd_t c;
    int   want;
    do_reset();
    send(rand_cmd(-1));
    send(rand_cmd(-1));
    want = (EFF_DEPTH < 2) ? EFF_DEPTH : 2;
    n_checks++; if (fifo_level !== LVL_W'(want)) $display("FAIL midrst_prefill: got %0d want %0d", fifo_level, want); else n_pass++;
    c = rand_cmd(-1);
    ir_in = c.ch; sr = c.jdo; vs_udr = 1'b1;
    tick(); tick();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    q.delete(); m_ovf = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      n_checks++;
      if (cmd_if.cmd_valid !== 1'b0 || fifo_level !== '0) $display("FAIL midrst_held cyc %0d: valid %b level %0d want 0/0", i, cmd_if.cmd_valid, fifo_level);
      else n_pass++;
    end
    n_checks++; if (overflow !== 1'b0) $display("FAIL midrst_overflow: got %b want 0", overflow); else n_pass++;
    vs_udr = 1'b0;
    repeat (3) tick();
    c = rand_cmd(-1);
    send(c);
    n_checks++; if (cmd_if.cmd_valid !== 1'b1 || {cmd_if.cmd_ch, cmd_if.cmd_jdo} !== c) $display("FAIL midrst_fresh: valid %b ch %0d jdo %h want 1/%0d/%h", cmd_if.cmd_valid, cmd_if.cmd_ch, cmd_if.cmd_jdo, c.ch, c.jdo); else n_pass++;
  endtask

  task automatic test_ir_update();
    do_reset();
    send(rand_cmd(-1));
    vs_uir = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      tick();
      if (e == 4) vs_uir = 1'b0;
      n_checks++;
      if (ir_update !== (e == 3)) $display("FAIL ir_update edge %0d: got %b want %b", e, ir_update, (e == 3));
      else n_pass++;
    end
    n_checks++; if (fifo_level !== LVL_W'(q.size()) || cmd_if.cmd_valid !== 1'b1) $display("FAIL ir_update_queue: level %0d valid %b want %0d/1", fifo_level, cmd_if.cmd_valid, q.size()); else n_pass++;
  endtask

  task automatic test_random(input int ncyc, input int ready_pct);
    int   hi_left, lo_left, due;
    bit   pop_p, clr_p, push_now;
    cmd_t pend;
    logic [NUM_CH-1:0] ea, en;
    do_reset();
    hi_left = 0; lo_left = 3; due = 0; pop_p = 1'b0; clr_p = 1'b0; pend = '0;
    for (int i = 0; i < ncyc; i++) begin
      tick();
      push_now = 1'b0;
      if (due > 0) begin
        due--;
        push_now = (due == 0);
      end
      model_apply(pop_p, push_now, pend, clr_p);
      n_checks++;
      if (fifo_level !== LVL_W'(q.size()) || cmd_if.cmd_valid !== (q.size() != 0) || overflow !== m_ovf)
        $display("FAIL rand_state cyc %0d: level %0d valid %b ovf %b want %0d/%b/%b", i, fifo_level, cmd_if.cmd_valid, overflow, q.size(), (q.size() != 0), m_ovf);
      else n_pass++;
      if (q.size() != 0) begin
        n_checks++;
        if ({cmd_if.cmd_ch, cmd_if.cmd_jdo} !== q[0]) $display("FAIL rand_head cyc %0d: ch %0d jdo %h want %0d/%h", i, cmd_if.cmd_ch, cmd_if.cmd_jdo, q[0].ch, q[0].jdo);
        else n_pass++;
      end
      cmd_if.cmd_ready = ($urandom_range(99) < ready_pct);
      clr_p = ($urandom_range(19) == 0);
      overflow_clr = clr_p;
      if (vs_udr) begin
        hi_left--;
        if (hi_left == 0) begin
          vs_udr  = 1'b0;
          lo_left = $urandom_range(4, 2);
        end
      end else if (lo_left > 0) begin
        lo_left--;
      end else begin
        pend = rand_cmd(-1);
        ir_in = pend.ch; sr = pend.jdo; vs_udr = 1'b1;
        hi_left = $urandom_range(4, 2);
        due = 3;
      end
      #1;
      pop_p = (q.size() != 0) && cmd_if.cmd_ready;
      ea = '0; en = '0;
      if (pop_p) begin
        if (q[0].jdo[ACT_BIT]) ea = onehot(q[0].ch);
        else                   en = onehot(q[0].ch);
      end
      n_checks++;
      if (cmd_if.take_action !== ea || cmd_if.take_no_action !== en) $display("FAIL rand_pulse cyc %0d: act %b noact %b want %b/%b", i, cmd_if.take_action, cmd_if.take_no_action, ea, en);
      else n_pass++;
    end
    vs_udr = 1'b0; cmd_if.cmd_ready = 1'b0; overflow_clr = 1'b0;
  endtask

  initial begin
    reset = 1'b1; vs_udr = 1'b0; vs_uir = 1'b0; overflow_clr = 1'b0;
    ir_in = '0; sr = '0; cmd_if.cmd_ready = 1'b0; m_ovf = 1'b0;
    test_reset();
    test_single();
    test_no_action();
    test_overflow();
    test_full_pop();
    test_reset_mid();
    test_ir_update();
    test_random(400, 50);
    test_random(300, 5);
    test_random(300, 90);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
